axis_fifo_reader: RTL and testbench
===================================

Name: axis_fifo_reader

Overview:
Read-side adapter that drains a synchronous FIFO and presents its contents as an AXI4-Stream master.
- Compensates for the FIFO's 1-cycle registered read latency (fifo_rd_en at edge E -> fifo_out valid after E).
- Uses an internal 2-entry output buffer, so the stream sustains 1 beat/cycle under continuous tready.
- Sits between the sync FIFO read port and any downstream AXIS slave.

Parameters:
num_data_bits, 32, width of FIFO data and m_axis_tdata
pkt_len, 16, beats per packet for tlast generation (only used with the optional feature); must be >= 1

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_out  input  num_data_bits  FIFO read data, valid the cycle after an accepted read
fifo_rd_en  output  1  FIFO read request (combinational)
m_axis_tdata  output  num_data_bits  stream data (registered)
m_axis_tvalid  output  1  stream valid (registered)
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  end of packet (registered; see Optional Feature)

Behaviour:
- Interface fixed: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values (async on reset rise):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Buffer occupancy occ=0, in-flight flag infl=0, beat counter=0.
  - fifo_rd_en forced 0 while reset is high.
- State:
  - occ in 0..2 counts valid buffered words; the head word drives tdata/tlast.
  - infl=1 means a read was issued last cycle and fifo_out carries valid data this cycle.
- pop = m_axis_tvalid && m_axis_tready.
- fifo_rd_en = !reset && !fifo_empty && (occ + infl - pop) < 2. A read is never issued unless a slot is guaranteed for the returning word.
- infl <= fifo_rd_en at each edge.
- When infl=1, fifo_out is captured at the edge:
  - into the head if the buffer is empty after the pop;
  - otherwise into the skid entry.
- On pop, the skid entry (if valid) moves to the head. Data order is strict FIFO order.
- m_axis_tvalid = (occ != 0), registered.
- AXIS rules:
  - tvalid never depends combinationally on tready.
  - Once tvalid=1, tvalid, tdata and tlast hold stable until pop.
- Latency: FIFO goes non-empty while the buffer is empty -> fifo_rd_en high that cycle (edge E) -> tvalid=1 after edge E+1.
- Throughput: with tready held 1 and FIFO non-empty, one beat per cycle with no bubbles after the first.
- Simultaneous pop and capture in the same cycle:
  - occ unchanged;
  - head takes the skid word if present, else the captured word.
- occ never exceeds 2; a capture with occ=2 and no pop is a design error (assertion).
- Backpressure with tready=0: at most 2 words are extracted from the FIFO; fifo_rd_en stays 0 until a pop.
- FIFO going empty mid-stream: tvalid drops only after the buffer drains. No garbage beat is produced, because infl only follows an accepted read.
- Reset mid-operation:
  - buffered and in-flight words are discarded;
  - a word read from the FIFO in the reset cycle is lost;
  - the system is expected to reset the FIFO together with this block.

Optional Feature:
Macro AXIS_FIFO_READER_TLAST_EN.
- Defined:
  - A beat counter 0..pkt_len-1 increments on each pop and wraps to 0 after pkt_len-1.
  - m_axis_tlast=1 on the beat that pops when counter==pkt_len-1, i.e. on every pkt_len-th beat.
  - tlast is registered alongside tdata and is stable while tvalid && !tready.
- Not defined: m_axis_tlast tied to 0; no counter logic.

Test Plan:
- Reset, then write 0xA0..0xA3 to an empty FIFO with tready=1 -> tvalid rises 2 edges after fifo_rd_en; beats A0,A1,A2,A3 on consecutive cycles, then tvalid=0.
- Preload 8 words, tready=0 for 10 cycles -> exactly 2 fifo_rd_en pulses; tvalid=1 with tdata=word0 stable. Release tready -> words 0..7 in order, no gap, no duplicate.
- Preload 6 words, tready toggling 1,0,1,0... -> 6 beats in order; handshake count = 6; fifo_rd_en never issued with occ+infl-pop >= 2.
- Assert reset asynchronously mid-stream (between edges) with 2 words buffered -> tvalid=0 and fifo_rd_en=0 immediately. After release, with the FIFO also reset and new data 0x55 written, the first beat is 0x55.
- AXIS_FIFO_READER_TLAST_EN defined, pkt_len=4, stream 10 words at full rate -> tlast=1 on beats 4 and 8 only. Stall tready on beat 8 -> tlast is held with tdata.
- Macro undefined -> tlast=0 for all beats of a 20-word stream.

Source files
------------

// File: rtl/axis_fifo_reader.sv
// Drains a sync FIFO (1-cycle read latency) into an AXI4-Stream master via a 2-entry head/skid buffer.
// Optional per-packet tlast generation is enabled with `define AXIS_FIFO_READER_TLAST_EN.
module axis_fifo_reader #(
  parameter int unsigned num_data_bits = 32,
  parameter int unsigned pkt_len       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty,
  input  logic [num_data_bits-1:0] fifo_out,
  output logic                     fifo_rd_en,
  output logic [num_data_bits-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);

  localparam int unsigned dw = num_data_bits;

  if (pkt_len == 0) begin : g_bad_pkt_len
    $error("axis_fifo_reader: pkt_len must be >= 1");
  end

  logic [1:0]    occ;
  logic [1:0]    occ_next;
  logic [1:0]    occ_after_pop;
  logic          infl;
  logic          tvalid_q;
  logic [dw-1:0] head_q;
  logic [dw-1:0] head_next;
  logic [dw-1:0] skid_q;
  logic [dw-1:0] skid_next;
  logic          pop;
  logic [2:0]    level;

  assign pop           = tvalid_q && m_axis_tready;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = head_q;

  // Only read when the returning word is guaranteed a slot next cycle.
  assign level      = 3'(occ) + 3'(infl) - 3'(pop);
  assign fifo_rd_en = !reset && !fifo_empty && (level < 3'd2);

  // Buffer update: pop shifts skid to head, returning word fills the first free slot.
  always_comb begin
    head_next     = head_q;
    skid_next     = skid_q;
    occ_after_pop = occ - 2'(pop);
    if (pop && (occ == 2'd2)) begin
      head_next = skid_q;
    end
    if (infl) begin
      if (occ_after_pop == 2'd0) begin
        head_next = fifo_out;
      end else begin
        skid_next = fifo_out;
      end
    end
    occ_next = occ_after_pop + 2'(infl);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      infl     <= 1'b0;
      tvalid_q <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
    end else begin
      assert (!(infl && (occ_after_pop == 2'd2)));
      occ      <= occ_next;
      infl     <= fifo_rd_en;
      tvalid_q <= (occ_next != 2'd0);
      head_q   <= head_next;
      skid_q   <= skid_next;
    end
  end

`ifdef AXIS_FIFO_READER_TLAST_EN
  localparam int unsigned cnt_w = (pkt_len > 1) ? $clog2(pkt_len) : 1;

  logic [cnt_w-1:0] cnt_q;
  logic [cnt_w-1:0] cnt_next;
  logic             tlast_q;

  // Counter tracks the position of the head beat; it only moves on pop, so tlast holds while stalled.
  always_comb begin
    cnt_next = cnt_q;
    if (pop) begin
      cnt_next = (cnt_q == cnt_w'(pkt_len - 1)) ? '0 : cnt_q + cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      tlast_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      tlast_q <= (cnt_next == cnt_w'(pkt_len - 1));
    end
  end

  assign m_axis_tlast = tlast_q;
`else
  assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Self-checking bench for axis_fifo_reader: behavioural FIFO, scoreboard of pushed words, directed + random phases.
module tb_axis_fifo_reader;

  localparam int unsigned DW  = 32;
  localparam int unsigned PKT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_out;
  logic          fifo_rd_en;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  always #5 clk = ~clk;

  axis_fifo_reader #(.num_data_bits(DW), .pkt_len(PKT)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_out      (fifo_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int passed = 0;
  int reads = 0;
  int beats = 0;
  int rd_pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Beat n (0-based since reset) ends a packet every PKT beats when tlast is enabled.
  function automatic logic exp_last(input int idx);
`ifdef AXIS_FIFO_READER_TLAST_EN
    return (idx % PKT) == (PKT - 1);
`else
    return (idx < 0);
`endif
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample at the edge, score beats, model the FIFO read latency, check stall stability.
  task automatic step();
    logic          rd_s;
    logic          pop_s;
    logic          stall_s;
    logic          l_s;
    logic [DW-1:0] d_s;
    logic [DW-1:0] w;
    @(posedge clk);
    rd_s    = fifo_rd_en;
    pop_s   = tvalid && tready;
    stall_s = tvalid && !tready;
    d_s     = tdata;
    l_s     = tlast;
    if (rd_s) begin
      check("rd_on_empty", 64'(fq.size() == 0), 64'(0));
      reads++;
      rd_pulses++;
    end
    if (pop_s) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'(1), 64'(0));
      end else begin
        w = exp_q.pop_front();
        check("beat_data", 64'(d_s), 64'(w));
      end
      check("beat_tlast", 64'(l_s), 64'(exp_last(beats)));
      beats++;
    end
    check("outstanding_le2", 64'((reads - beats) <= 2), 64'(1));
    #1;
    if (rd_s && fq.size() > 0) begin
      fifo_out   = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
    if (stall_s) begin
      check("hold_valid", 64'(tvalid), 64'(1));
      check("hold_data", 64'(tdata), 64'(d_s));
      check("hold_last", 64'(tlast), 64'(l_s));
    end
  endtask

  task automatic clear_model();
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    fifo_out   = '0;
    reads      = 0;
    beats      = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'(1));
  endtask

  initial begin
    int n;
    int b0;
    logic [DW-1:0] w0;

    reset  = 1'b1;
    tready = 1'b0;
    clear_model();
    repeat (2) step();
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
    reset = 1'b0;

    // Latency and full-rate streaming of four words.
    tready = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(32'hA0 + i));
    #1;
    check("t1_rd_en", 64'(fifo_rd_en), 64'(1));
    step();
    check("t1_tvalid_e", 64'(tvalid), 64'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_tvalid", 64'(tvalid), 64'(1));
      check("t1_tdata", 64'(tdata), 64'(32'hA0 + k));
    end
    step();
    check("t1_tvalid_end", 64'(tvalid), 64'(0));

    // Backpressure: only two words leave the FIFO, then release with no gap.
    tready = 1'b0;
    w0 = DW'($urandom);
    push(w0);
    for (int i = 1; i < 8; i++) push(DW'($urandom));
    rd_pulses = 0;
    repeat (10) step();
    check("t2_rd_pulses", 64'(rd_pulses), 64'(2));
    check("t2_tvalid", 64'(tvalid), 64'(1));
    check("t2_tdata", 64'(tdata), 64'(w0));
    tready = 1'b1;
    b0 = beats;
    drain(40, n);
    check("t2_no_gap", 64'(n), 64'(8));
    check("t2_beats", 64'(beats - b0), 64'(8));

    // Alternating tready.
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    b0 = beats;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 60) begin
      tready = n[0];
      step();
      n++;
    end
    check("t3_timeout", 64'(n < 60), 64'(1));
    check("t3_beats", 64'(beats - b0), 64'(6));

    // Asynchronous reset mid-stream with two words buffered.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    repeat (4) step();
    check("t4_buffered", 64'(tvalid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("t4_tvalid", 64'(tvalid), 64'(0));
    check("t4_rd_en", 64'(fifo_rd_en), 64'(0));
    do_reset();
    push(DW'(32'h55));
    tready = 1'b1;
    drain(20, n);
    check("t4_beats", 64'(beats), 64'(1));

    // tlast pattern over 20 beats with a stall on beat 8.
    do_reset();
    for (int i = 0; i < 20; i++) push(DW'(32'h100 + i));
    tready = 1'b1;
    n = 0;
    while (beats < 7 && n < 100) begin
      step();
      n++;
    end
    check("t5_reach7", 64'(beats), 64'(7));
    tready = 1'b0;
    repeat (3) step();
    check("t5_stall_last", 64'(tlast), 64'(exp_last(7)));
    check("t5_stall_data", 64'(tdata), 64'(32'h107));
    tready = 1'b1;
    drain(60, n);
    check("t5_beats", 64'(beats), 64'(20));

    // Random pushes and random backpressure against the scoreboard.
    b0 = beats;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      tready = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 1 && fq.size() < 16) begin
        push(DW'($urandom));
        n++;
      end
      step();
    end
    tready = 1'b1;
    drain(100, b0);
    check("t6_beats", 64'(beats), 64'(20 + n));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
